// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Control bundle between the multicycle MIPS control FSM and its datapath.
//   op, funct      : instruction fields decoded from the instruction register
//   pcWriteCond    : PC write qualified by ALU zero
//   pcWrite        : unconditional PC write
//   iOrD           : memory address select (0=PC, 1=ALUOut)
//   memRead        : memory read enable
//   memWrite       : memory write enable
//   memToReg       : register write-data select (1=MDR, 0=ALUOut)
//   irWrite        : instruction register load
//   pcSource       : next-PC select (00=ALU result, 01=ALUOut, 10=jump target)
//   aluControl     : ALU op (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   aluSrcB        : ALU B select (00=regB, 01=4, 10=imm, 11=imm<<2)
//   aluSrcA        : ALU A select (0=PC, 1=regA)
//   regWrite       : register-file write enable
//   regDst         : destination select (1=rd, 0=rt)
//   illegal        : one-cycle pulse on an unsupported op or funct
// Modports: master = control FSM, slave = datapath.
// Handshake: there is no valid/ready pair; every control output is a level
// that holds for exactly one clock cycle per FSM state and the datapath acts
// on it at the next rising edge.
interface multicycle_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       pcWriteCond;
  logic       pcWrite;
  logic       iOrD;
  logic       memRead;
  logic       memWrite;
  logic       memToReg;
  logic       irWrite;
  logic [1:0] pcSource;
  logic [2:0] aluControl;
  logic [1:0] aluSrcB;
  logic       aluSrcA;
  logic       regWrite;
  logic       regDst;
  logic       illegal;

  modport master (
    input  op, funct,
    output pcWriteCond, pcWrite, iOrD, memRead, memWrite, memToReg, irWrite,
           pcSource, aluControl, aluSrcB, aluSrcA, regWrite, regDst, illegal
  );

  modport slave (
    output op, funct,
    input  pcWriteCond, pcWrite, iOrD, memRead, memWrite, memToReg, irWrite,
           pcSource, aluControl, aluSrcB, aluSrcA, regWrite, regDst, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// Main Moore control FSM of the multicycle MIPS core. Each instruction runs
// FETCH -> DECODE -> (execute states) -> FETCH, taking 3 to 5 cycles.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; loads FETCH and masks all write
//            enables and illegal while high
//   bus    : multicycle_control_if.master (op/funct in, control outputs out)
//   state  : current FSM state, zero-extended to STATE_WIDTH (debug)
// Parameter STATE_WIDTH (>= 4) sizes the state debug output.
// Build option: define MULTICYCLE_CTRL_ADDI_EN to implement addi (op 001000)
// through ADDIEX/ADDIWB; without it addi is reported as illegal.
module multicycle_control #(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus,
  output logic [STATE_WIDTH-1:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    JEX     = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_d;

  // Raw per-state decode before the reset mask is applied.
  logic       pc_write_cond;
  logic       pc_write;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       illegal_raw;

  // R-type funct decode; funct_ok low means the funct is unsupported.
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = FETCH;
    pc_write_cond  = 1'b0;
    pc_write       = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    reg_write      = 1'b0;
    illegal_raw    = 1'b0;
    bus.iOrD       = 1'b0;
    bus.memRead    = 1'b0;
    bus.memToReg   = 1'b0;
    bus.pcSource   = 2'b00;
    bus.aluControl = 3'b000;
    bus.aluSrcB    = 2'b00;
    bus.aluSrcA    = 1'b0;
    bus.regDst     = 1'b0;

    case (state_q)
      FETCH: begin
        bus.memRead    = 1'b1;
        ir_write       = 1'b1;
        bus.aluSrcB    = 2'b01;
        bus.aluControl = ALU_ADD;
        pc_write       = 1'b1;
        state_d        = DECODE;
      end
      DECODE: begin
        // Branch target PC + (imm << 2) is precomputed into ALUOut here.
        bus.aluSrcB    = 2'b11;
        bus.aluControl = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE: begin
            if (funct_ok) state_d     = RTYPEEX;
            else          illegal_raw = 1'b1;
          end
          OP_BEQ: state_d = BEQEX;
          OP_J:   state_d = JEX;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI: state_d = ADDIEX;
`endif
          // Unsupported op: flag it and refetch; PC already moved on by 4.
          default: illegal_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.aluSrcA    = 1'b1;
        bus.aluSrcB    = 2'b10;
        bus.aluControl = ALU_ADD;
        state_d        = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iOrD    = 1'b1;
        bus.memRead = 1'b1;
        state_d     = MEMWB;
      end
      MEMWB: begin
        bus.memToReg = 1'b1;
        reg_write    = 1'b1;
      end
      MEMWR: begin
        bus.iOrD  = 1'b1;
        mem_write = 1'b1;
      end
      RTYPEEX: begin
        bus.aluSrcA    = 1'b1;
        bus.aluControl = funct_alu;
        state_d        = RTYPEWB;
      end
      RTYPEWB: begin
        bus.regDst = 1'b1;
        reg_write  = 1'b1;
      end
      BEQEX: begin
        bus.aluSrcA    = 1'b1;
        bus.aluControl = ALU_SUB;
        pc_write_cond  = 1'b1;
        bus.pcSource   = 2'b01;
      end
      JEX: begin
        pc_write     = 1'b1;
        bus.pcSource = 2'b10;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDIEX: begin
        bus.aluSrcA    = 1'b1;
        bus.aluSrcB    = 2'b10;
        bus.aluControl = ALU_ADD;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
`endif
      // Unused encodings fall back to FETCH with every output low.
      default: state_d = FETCH;
    endcase
  end

  // Reset masks every state-changing strobe so an abandoned instruction
  // cannot commit a partial write in the cycle reset is applied.
  assign bus.pcWriteCond = pc_write_cond & ~reset;
  assign bus.pcWrite     = pc_write      & ~reset;
  assign bus.memWrite    = mem_write     & ~reset;
  assign bus.irWrite     = ir_write      & ~reset;
  assign bus.regWrite    = reg_write     & ~reset;
  assign bus.illegal     = illegal_raw   & ~reset;

  assign state = STATE_WIDTH'(state_q);

endmodule
